timelock_ctrl_param: RTL
========================

// Module: timelock_ctrl_param
// PURPOSE
//  Parametrised command controller between a byte stream (UART rx/tx, same clock
//  domain) and a timelock squaring core. Nibble-serial loading of a carry-save
//  operand {xc,xs}, COMPUTE start, result capture, readback, STATUS, ABORT, watchdog.
//  Successor to the fixed 184-bit controller; adds tx valid/ready and error replies.
// PARAMETERS
//  WIDTH      184  bits per carry-save half (xs/xc/ys/yc); even, >=4, 2*WIDTH%4==0
//  TMO_W      32   width of compute watchdog counter
//  TIMEOUT    0    compute cycles before forced abort; 0 = watchdog disabled
// PORTS
//  clk       in   1        single clock; all logic rising-edge
//  rst_n     in   1        synchronous, active-low reset
//  rx_valid  in   1        one-cycle pulse: rx_byte valid
//  rx_byte   in   8        [3:0] command, [7:4] data nibble
//  tx_valid  out  1        reply byte pending; held until tx_ready
//  tx_byte   out  8        reply byte; stable while tx_valid
//  tx_ready  in   1        transmitter accepts when tx_valid&tx_ready
//  core_ld   out  1        1 = core loading/idle, 0 = core computing
//  core_xs   out  WIDTH    operand sum half    = x[WIDTH-1:0]
//  core_xc   out  WIDTH    operand carry half  = x[2*WIDTH-1:WIDTH]
//  core_dn   in   1        core done (valid only while core_ld==0)
//  core_ys   in   WIDTH    result sum half
//  core_yc   in   WIDTH    result carry half
//  busy      out  1        1 in WAIT state
// BEHAVIOUR
//  Reset (rst_n==0 at edge): state=IDLE, x=0, core_ld=1, tx_valid=0, tx_byte=0,
//   busy=0, ovr=0, tmo=0, wdog=0. Reset mid-compute: core_ld=1 next cycle.
//  Register x[2*WIDTH-1:0]; states IDLE, WAIT, WRITE.
//  IDLE, rx_valid=1, cmd=rx_byte[3:0]:
//   0 LOAD : x<={rx_byte[7:4],x[2W-1:4]}; reply {old x[3:0],4'h1}; ->WRITE
//   4 READ : x<={x[3:0],x[2W-1:4]} (rotate); reply {old x[3:0],4'h4}; ->WRITE
//   2 COMPUTE: core_ld<=0, wdog<=0, busy<=1; ->WAIT (no reply yet)
//   5 STATUS : reply {ovr,tmo,2'b00,4'h5}; clear ovr,tmo; ->WRITE
//   6 ABORT  : reply 8'h07 (nothing to abort); ->WRITE
//   other    : reply {cmd,4'hF}; ->WRITE; x unchanged
//  WAIT (core_ld=0), priority high->low each cycle:
//   core_dn: x<={core_yc,core_ys}; core_ld<=1; reply 8'h03; ->WRITE
//   rx_valid & cmd==6: core_ld<=1; reply 8'h07; x unchanged; ->WRITE
//   TIMEOUT!=0 & wdog==TIMEOUT-1: core_ld<=1; tmo<=1; reply 8'h0E; ->WRITE
//   else wdog++ (saturating at all-ones); other rx bytes: dropped, ovr<=1
//  WRITE: tx_valid=1 with registered tx_byte; on tx_valid&tx_ready ->IDLE,
//   tx_valid<=0 same edge. rx_valid in WRITE (incl. accept cycle): dropped, ovr<=1.
//  Latency: IDLE rx_valid -> tx_valid at +1 cycle; dn -> tx_valid at +1 cycle;
//   COMPUTE rx -> core_ld low at +1; leaving WAIT -> core_ld high at +1.
//  busy==(state==WAIT); core_xs/core_xc are combinational slices of x.
//  Exactly one reply per accepted command except COMPUTE (reply at end of WAIT).
//  Nibble order: first LOAD lands in x[2W-1:2W-4]; after 2W/4 LOADs the first
//   nibble is at x[3:0]; LOAD reply streams out previous contents LSB-first.
// STRUCTURE
//  Package timelock_ctrl_pkg: command codes (LOAD=0,ACKLOAD=1,COMPUTE=2,
//   ACKCOMPUTE=3,READ=4,STATUS=5,ABORT=6,ACKABORT=7,TMO=E,ERR=F), state enum.
//  Sub-module timelock_watchdog: TMO_W counter, clear/enable/expire(TIMEOUT).
// TESTING (bench WIDTH=8, 2W=16, TIMEOUT=20, tx_ready tied 1 unless stated)
//  Reset: after rst_n low 1 cycle -> core_ld=1, tx_valid=0, x=16'h0000, busy=0.
//  LOAD 0xA0,0xB0,0xC0,0xD0 -> replies 01,01,01,01; x=16'hDCBA; then READ x4 ->
//   replies A4,B4,C4,D4, x back to 16'hDCBA.
//  COMPUTE, core_dn after 5 cycles with ys=8'h12, yc=8'h34 -> reply 03, x=16'h3412,
//   core_ld low exactly 6 cycles; LOAD in WAIT -> ovr set; STATUS -> 85, then 05.
//  COMPUTE, no dn -> reply 0E at wdog expiry, core_ld=1; STATUS -> 45.
//  COMPUTE then ABORT (0x06) -> reply 07, x unchanged; ABORT+core_dn same cycle ->
//   reply 03 only. Unknown cmd 0x39 -> reply 9F.
//  tx_ready=0 for 10 cycles: tx_valid/tx_byte held stable; rst_n low in WAIT ->
//   core_ld=1, tx_valid=0 next cycle.

Source files
------------

// File: rtl/timelock_ctrl_pkg.sv
// Shared command codes and FSM state type for the timelock command controller.
package timelock_ctrl_pkg;

  // Low nibble of every rx command and tx reply byte.
  typedef enum logic [3:0] {
    CmdLoad       = 4'h0,
    CmdAckLoad    = 4'h1,
    CmdCompute    = 4'h2,
    CmdAckCompute = 4'h3,
    CmdRead       = 4'h4,
    CmdStatus     = 4'h5,
    CmdAbort      = 4'h6,
    CmdAckAbort   = 4'h7,
    CmdTmo        = 4'hE,
    CmdErr        = 4'hF
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StWrite
  } state_e;

  // Reply byte: payload nibble on top, code nibble below.
  function automatic logic [7:0] mk_reply(input logic [3:0] hi, input cmd_e code);
    return {hi, 4'(code)};
  endfunction

endpackage

// File: rtl/timelock_ctrl_param_if.sv
// Byte-stream and squaring-core signals of the timelock controller.
interface timelock_ctrl_param_if #(
  parameter int unsigned WIDTH = 184
);
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic             tx_valid;
  logic [7:0]       tx_byte;
  logic             tx_ready;
  logic             core_ld;
  logic [WIDTH-1:0] core_xs;
  logic [WIDTH-1:0] core_xc;
  logic             core_dn;
  logic [WIDTH-1:0] core_ys;
  logic [WIDTH-1:0] core_yc;

  // Controller side.
  modport master (
    input  rx_valid, rx_byte, tx_ready, core_dn, core_ys, core_yc,
    output tx_valid, tx_byte, core_ld, core_xs, core_xc
  );

  // UART / core side.
  modport slave (
    output rx_valid, rx_byte, tx_ready, core_dn, core_ys, core_yc,
    input  tx_valid, tx_byte, core_ld, core_xs, core_xc
  );
endinterface

// File: rtl/timelock_watchdog.sv
// Compute watchdog: saturating cycle counter that flags the last allowed cycle.
module timelock_watchdog #(
  parameter int unsigned TMO_W   = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] LastCnt = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q;

  // Clear on compute start, otherwise count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // TIMEOUT of zero disables the watchdog entirely.
  assign expire_o = (TIMEOUT != 0) && (cnt_q == LastCnt);

endmodule

// File: rtl/timelock_ctrl_param.sv
// Command controller between a byte stream and a carry-save timelock squaring core.
module timelock_ctrl_param
  import timelock_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 184,
  parameter int unsigned TMO_W   = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  timelock_ctrl_param_if.master bus,
  output logic                  busy
);

  localparam int unsigned XW = 2 * WIDTH;

  state_e          state_q;
  logic [XW-1:0]   x_q;
  logic            core_ld_q;
  logic            tx_valid_q;
  logic [7:0]      tx_byte_q;
  logic            ovr_q;
  logic            tmo_q;

  logic [3:0]      cmd;
  logic [3:0]      rx_nib;
  logic            wdog_clr;
  logic            wdog_en;
  logic            wdog_expire;
  logic            abort_req;

  assign cmd       = bus.rx_byte[3:0];
  assign rx_nib    = bus.rx_byte[7:4];
  assign abort_req = bus.rx_valid && (cmd == 4'(CmdAbort));

  // Watchdog restarts on COMPUTE and only advances on WAIT cycles nothing else claimed.
  always_comb begin
    wdog_clr = (state_q == StIdle) && bus.rx_valid && (cmd == 4'(CmdCompute));
    wdog_en  = (state_q == StWait) && !bus.core_dn && !abort_req && !wdog_expire;
  end

  timelock_watchdog #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wdog_clr),
    .en_i     (wdog_en),
    .expire_o (wdog_expire)
  );

  // Command FSM; every output it drives is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      core_ld_q  <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.rx_valid) begin
            tx_valid_q <= 1'b1;
            state_q    <= StWrite;
            case (cmd)
              4'(CmdLoad): begin
                x_q       <= {rx_nib, x_q[XW-1:4]};
                tx_byte_q <= mk_reply(x_q[3:0], CmdAckLoad);
              end
              4'(CmdRead): begin
                x_q       <= {x_q[3:0], x_q[XW-1:4]};
                tx_byte_q <= mk_reply(x_q[3:0], CmdRead);
              end
              4'(CmdCompute): begin
                // Reply is deferred until the core finishes or is stopped.
                core_ld_q  <= 1'b0;
                tx_valid_q <= 1'b0;
                state_q    <= StWait;
              end
              4'(CmdStatus): begin
                tx_byte_q <= mk_reply({ovr_q, tmo_q, 2'b00}, CmdStatus);
                ovr_q     <= 1'b0;
                tmo_q     <= 1'b0;
              end
              4'(CmdAbort): begin
                tx_byte_q <= mk_reply(4'h0, CmdAckAbort);
              end
              default: begin
                tx_byte_q <= mk_reply(cmd, CmdErr);
              end
            endcase
          end
        end

        StWait: begin
          if (bus.core_dn) begin
            x_q        <= {bus.core_yc, bus.core_ys};
            core_ld_q  <= 1'b1;
            tx_byte_q  <= mk_reply(4'h0, CmdAckCompute);
            tx_valid_q <= 1'b1;
            state_q    <= StWrite;
          end else if (abort_req) begin
            core_ld_q  <= 1'b1;
            tx_byte_q  <= mk_reply(4'h0, CmdAckAbort);
            tx_valid_q <= 1'b1;
            state_q    <= StWrite;
          end else if (wdog_expire) begin
            core_ld_q  <= 1'b1;
            tmo_q      <= 1'b1;
            tx_byte_q  <= mk_reply(4'h0, CmdTmo);
            tx_valid_q <= 1'b1;
            state_q    <= StWrite;
          end else if (bus.rx_valid) begin
            ovr_q <= 1'b1;
          end
        end

        StWrite: begin
          // No input buffering: anything arriving while a reply is pending is lost.
          if (bus.rx_valid) begin
            ovr_q <= 1'b1;
          end
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.core_ld  = core_ld_q;
  assign bus.core_xs  = x_q[WIDTH-1:0];
  assign bus.core_xc  = x_q[XW-1:WIDTH];
  assign busy         = (state_q == StWait);

endmodule
